instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
// - Write-side counterpart of the nibble-organised instruction memory (4-bit cells; a 16-bit instruction
//   occupies 4 consecutive addresses, most significant nibble at the lowest address).
// - Accepts 16-bit instruction words over a valid/ready stream and serialises each into 4 nibble writes.
// - Sits between the program-download path (UART/testbench) and the memory's write port; runs before the CPU.
// PARAMETERS
// - MEM_DEPTH      128  number of 4-bit cells in the instruction memory
// - ADDR_WIDTH     16   width of memory addresses (matches PC width)
// - COUNT_WIDTH    16   width of WordCount
// PORTS
// - Clock            in   1           single clock, all state updates on rising edge
// - Reset            in   1           synchronous, active-high
// - Start            in   1           begin a load session at StartAddress (sampled in IDLE only)
// - StartAddress     in   ADDR_WIDTH  nibble address of first instruction
// - WordIn           in   16          instruction word to write
// - WordValid        in   1           WordIn valid
// - WordLast         in   1           WordIn is the final word of the session (qualified by WordValid)
// - WordReady        out  1           loader accepts WordIn this cycle
// - MemWriteEnable   out  1           memory write strobe
// - MemWriteAddress  out  ADDR_WIDTH  nibble address being written
// - MemWriteData     out  4           nibble being written
// - Busy             out  1           session in progress (any state but IDLE)
// - Done             out  1           one-cycle pulse: session completed normally
// - Error            out  1           sticky: address range exceeded; cleared by Start or Reset
// - WordCount        out  COUNT_WIDTH words fully written in current/last session
// BEHAVIOUR
// - Reset (sync, active-high): state IDLE; WordReady, MemWriteEnable, Busy, Done, Error = 0;
//   MemWriteAddress, MemWriteData, WordCount = 0. Reset wins over all other inputs.
// - States: IDLE, WAIT_WORD, WRITE, DONE, ERROR.
// - IDLE: Start=1 -> latch Base=StartAddress, clear WordCount and Error, go WAIT_WORD. Otherwise hold.
// - WAIT_WORD: range check first: if Base+3 > MEM_DEPTH-1 (compare at ADDR_WIDTH+1 bits, no wrap)
//   -> ERROR, WordReady=0. Else WordReady=1; on WordValid&&WordReady latch WordIn, WordLast, go WRITE.
// - WRITE: nibble index k = 0..3, one per cycle; MemWriteEnable=1, MemWriteAddress=Base+k,
//   MemWriteData=Word[15-4k -: 4]. WordReady=0 throughout. After k=3: Base+=4, WordCount+=1;
//   latched Last -> DONE, else -> WAIT_WORD.
// - Latency: word accepted at edge N -> writes visible on cycles N+1..N+4; max throughput 1 word / 5 cycles.
// - DONE: Done=1 for exactly one cycle, then IDLE. WordCount holds until next Start.
// - ERROR: Error=1 set on entry, stays until Start (in IDLE) or Reset; state returns to IDLE next cycle.
//   Words already written remain; no partial word is ever started past range.
// - Start while Busy is ignored. WordValid in IDLE/WRITE/DONE is not accepted (WordReady=0).
// - Reset mid-WRITE: MemWriteEnable drops at that edge; partially written nibbles stay in memory.
// - No memory reads; the loader never drives writes outside WRITE.
// STRUCTURE
// - Shared include instr_mem_defs.vh: NIBBLE_WIDTH=4, INSTR_WIDTH=16, NIBBLES_PER_INSTR=4,
//   MEM_DEPTH default, loader state encodings (shared with instruction memory and CPU top).
// - One sub-module: instr_nibble_serializer (16-bit holding register + 2-bit nibble index,
//   outputs nibble, offset, last-nibble flag). FSM, Base and WordCount stay in this module.
// TESTING
// - Reset; Start @0; one word 16'hA5C3 with Last -> writes (0,A),(1,5),(2,C),(3,3) on 4 consecutive
//   cycles, Done pulse 1 cycle later, WordCount=1, Busy=0.
// - Start @8; 3 words 16'h1234,16'h5678,16'h9ABC with WordValid gaps -> addresses 8..19 written
//   in order, WordReady=0 during every WRITE, WordCount=3.
// - MEM_DEPTH=128, Start @124, two words -> first written to 124..127, second never accepted,
//   Error=1, WordReady=0, WordCount=1; next Start clears Error.
// - Start @126 -> ERROR immediately, no MemWriteEnable ever, Error=1.
// - Reset asserted after 2nd nibble of a word -> MemWriteEnable=0 next cycle, IDLE, all outputs reset.
// - Start pulsed during WRITE and WordValid held high from Start cycle -> Start ignored; word
//   accepted only in first WAIT_WORD cycle.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the nibble-organised instruction memory and its loader.
package instr_mem_loader_pkg;

    localparam int NIBBLE_WIDTH      = 4;
    localparam int INSTR_WIDTH       = 16;
    localparam int NIBBLES_PER_INSTR = 4;
    localparam int MEM_DEPTH_DEFAULT = 128;

    // Loader session states, also observed by the instruction memory and CPU top.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_WRITE     = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4
    } loader_state_t;

    // Nibble k of an instruction, most significant nibble first.
    function automatic logic [NIBBLE_WIDTH-1:0] nibble_of(
        input logic [INSTR_WIDTH-1:0] word,
        input logic [1:0]             k
    );
        logic [NIBBLE_WIDTH-1:0] n;
        case (k)
            2'd0:    n = word[15:12];
            2'd1:    n = word[11:8];
            2'd2:    n = word[7:4];
            default: n = word[3:0];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/instr_mem_loader_serializer.sv
// Holds one instruction word and steps through its four nibbles, MSB nibble first.
module instr_nibble_serializer
    import instr_mem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    advance,
    input  logic [INSTR_WIDTH-1:0]  word_in,
    output logic [NIBBLE_WIDTH-1:0] nibble,
    output logic [1:0]              offset,
    output logic                    last_nibble
);

    logic [INSTR_WIDTH-1:0] word_q;
    logic [1:0]             index_q;

    // Capture a new word (index restarts at 0) or step to the next nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            index_q <= '0;
        end else if (load) begin
            word_q  <= word_in;
            index_q <= '0;
        end else if (advance) begin
            index_q <= index_q + 2'd1;
        end
    end

    // Current nibble, its offset from the word base, and end-of-word flag.
    always_comb begin
        nibble      = nibble_of(word_q, index_q);
        offset      = index_q;
        last_nibble = (index_q == 2'(NIBBLES_PER_INSTR - 1));
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Serialises 16-bit instruction words from a valid/ready stream into nibble writes
// for the instruction memory, with range checking against the memory depth.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int MEM_DEPTH   = MEM_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [ADDR_WIDTH-1:0]   StartAddress,
    input  logic [INSTR_WIDTH-1:0]  WordIn,
    input  logic                    WordValid,
    input  logic                    WordLast,
    output logic                    WordReady,
    output logic                    MemWriteEnable,
    output logic [ADDR_WIDTH-1:0]   MemWriteAddress,
    output logic [NIBBLE_WIDTH-1:0] MemWriteData,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error,
    output logic [COUNT_WIDTH-1:0]  WordCount
);

    localparam logic [ADDR_WIDTH:0] LAST_CELL = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] WORD_SPAN = (ADDR_WIDTH + 1)'(NIBBLES_PER_INSTR - 1);

    loader_state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]   base;
    logic [COUNT_WIDTH-1:0]  word_count;
    logic                    error_q;
    logic                    last_q;
    logic                    in_range;
    logic                    start_session;
    logic                    accept;
    logic                    set_error;
    logic                    word_done;
    logic [NIBBLE_WIDTH-1:0] ser_nibble;
    logic [1:0]              ser_offset;
    logic                    ser_last;

    instr_nibble_serializer u_serializer (
        .clk         (Clock),
        .rst         (Reset),
        .load        (accept),
        .advance     (state == ST_WRITE),
        .word_in     (WordIn),
        .nibble      (ser_nibble),
        .offset      (ser_offset),
        .last_nibble (ser_last)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and all stream/memory/status outputs.
    always_comb begin
        state_nx        = state;
        WordReady       = 1'b0;
        MemWriteEnable  = 1'b0;
        MemWriteAddress = '0;
        MemWriteData    = '0;
        Done            = 1'b0;
        start_session   = 1'b0;
        accept          = 1'b0;
        set_error       = 1'b0;
        word_done       = 1'b0;
        // Widened by one bit so a base near the top of the address space cannot wrap.
        in_range        = (({1'b0, base} + WORD_SPAN) <= LAST_CELL);

        unique case (state)
            ST_IDLE: begin
                if (Start) begin
                    start_session = 1'b1;
                    state_nx      = ST_WAIT_WORD;
                end
            end
            ST_WAIT_WORD: begin
                if (!in_range) begin
                    set_error = 1'b1;
                    state_nx  = ST_ERROR;
                end else begin
                    WordReady = 1'b1;
                    if (WordValid) begin
                        accept   = 1'b1;
                        state_nx = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                MemWriteEnable  = 1'b1;
                MemWriteAddress = base + ADDR_WIDTH'(ser_offset);
                MemWriteData    = ser_nibble;
                if (ser_last) begin
                    word_done = 1'b1;
                    state_nx  = last_q ? ST_DONE : ST_WAIT_WORD;
                end
            end
            ST_DONE: begin
                Done     = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_ERROR: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Session datapath: write base, completed-word count, sticky error, last-word flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            base       <= '0;
            word_count <= '0;
            error_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (start_session) begin
                base       <= StartAddress;
                word_count <= '0;
                error_q    <= 1'b0;
            end
            if (set_error) error_q <= 1'b1;
            if (accept)    last_q  <= WordLast;
            if (word_done) begin
                base       <= base + ADDR_WIDTH'(NIBBLES_PER_INSTR);
                word_count <= word_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Status outputs.
    always_comb begin
        Busy      = (state != ST_IDLE);
        Error     = error_q;
        WordCount = word_count;
    end

endmodule
